// File: rtl/mem_vector_access_if.sv
// Bundle between the MEM-stage sequencer, the EX/MEM pipeline bundle and the single-word data memory.
// master = the sequencer (drives the memory port), slave = pipeline/memory side.
interface mem_vector_access_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 24,
    parameter int ADDR_W = 21
);
    logic                      req_valid;
    logic [3:0]                mem_ctrl;
    logic [ADDR_W-1:0]         base_addr;
    logic [LANES*LANE_W-1:0]   wdata;
    logic                      stall;
    logic                      done;
    logic [LANES*LANE_W-1:0]   rdata;
    logic                      m_req;
    logic                      m_we;
    logic [ADDR_W-1:0]         m_addr;
    logic [LANE_W-1:0]         m_wdata;
    logic                      m_ack;
    logic [LANE_W-1:0]         m_rdata;

    modport master (
        input  req_valid, mem_ctrl, base_addr, wdata, m_ack, m_rdata,
        output stall, done, rdata, m_req, m_we, m_addr, m_wdata
    );

    modport slave (
        output req_valid, mem_ctrl, base_addr, wdata, m_ack, m_rdata,
        input  stall, done, rdata, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_vector_access.sv
// MEM-stage access sequencer: runs scalar or vector loads/stores lane by lane over a
// single-word memory port, assembles load data and stalls the pipeline while busy.
module mem_vector_access #(
    parameter int LANES  = 8,
    parameter int LANE_W = 24,
    parameter int ADDR_W = 21
) (
    input  logic                clk,
    input  logic                rst,
    mem_vector_access_if.master bus
);
    localparam int VEC_W   = LANES * LANE_W;
    localparam int LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_r;
    logic [LANE_CW-1:0] lane_r;
    logic [LANE_CW-1:0] last_lane_r;
    logic [VEC_W-1:0]   wdata_sh_r;
    logic               start_s;

    // Only a genuine read or write (not both, not neither) starts a transaction.
    assign start_s = (state_r == IDLE) && bus.req_valid && (bus.mem_ctrl[0] ^ bus.mem_ctrl[1]);

    // Stall covers the start cycle too so the EX/MEM bundle is held until the first ack.
    assign bus.stall = start_s || (state_r == ACCESS);

    // Transaction FSM; all memory-port and result outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            lane_r      <= '0;
            last_lane_r <= '0;
            wdata_sh_r  <= '0;
            bus.done    <= 1'b0;
            bus.rdata   <= '0;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (start_s) begin
                        state_r     <= ACCESS;
                        lane_r      <= '0;
                        last_lane_r <= bus.mem_ctrl[2] ? LANE_CW'(LANES - 1) : '0;
                        // Base address and store data are captured so the port stays
                        // stable regardless of what the upstream stage does meanwhile.
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.mem_ctrl[1];
                        bus.m_addr  <= bus.base_addr;
                        bus.m_wdata <= bus.wdata[LANE_W-1:0];
                        wdata_sh_r  <= bus.wdata >> LANE_W;
                        if (bus.mem_ctrl[0]) begin
                            bus.rdata <= '0;
                        end else begin
                            bus.rdata <= bus.rdata;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (bus.m_ack) begin
                        if (!bus.m_we) begin
                            bus.rdata[lane_r*LANE_W +: LANE_W] <= bus.m_rdata;
                        end else begin
                            bus.rdata <= bus.rdata;
                        end
                        if (lane_r == last_lane_r) begin
                            state_r   <= DONE;
                            bus.m_req <= 1'b0;
                            bus.done  <= 1'b1;
                        end else begin
                            // Next lane is presented right after the ack: no idle gap.
                            lane_r      <= lane_r + LANE_CW'(1);
                            bus.m_addr  <= bus.m_addr + ADDR_W'(1);
                            bus.m_wdata <= wdata_sh_r[LANE_W-1:0];
                            wdata_sh_r  <= wdata_sh_r >> LANE_W;
                        end
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    bus.done  <= 1'b0;
                    bus.m_req <= 1'b0;
                end
            endcase
        end
    end
endmodule
